// File: rtl/timing_realign_pkg.sv
// Shared definitions for the timing realignment block: timing-word layout and defaults.
package timing_realign_pkg;

  localparam int unsigned TW_DEFAULT    = 38;
  localparam int unsigned DW_DEFAULT    = 12;
  localparam int unsigned DEPTH_DEFAULT = 8;

  // Field offsets inside the VGA timing word
  localparam int unsigned HCOUNT_LSB = 0;
  localparam int unsigned HCOUNT_W   = 11;
  localparam int unsigned VCOUNT_LSB = 11;
  localparam int unsigned VCOUNT_W   = 11;
  localparam int unsigned HSYNC_BIT  = 22;
  localparam int unsigned VSYNC_BIT  = 23;
  localparam int unsigned HBLNK_BIT  = 24;
  localparam int unsigned VBLNK_BIT  = 25;
  localparam int unsigned FIELDS_W   = 26;

  // Packed view of the default-width timing word, upper bits are padding
  typedef struct packed {
    logic [TW_DEFAULT-FIELDS_W-1:0] pad;
    logic                           vblnk;
    logic                           hblnk;
    logic                           vsync;
    logic                           hsync;
    logic [VCOUNT_W-1:0]            vcount;
    logic [HCOUNT_W-1:0]            hcount;
  } timing_t;

endpackage

// File: rtl/timing_realign_if.sv
// Request/response/output bundle of the timing realignment block.
interface timing_realign_if
  import timing_realign_pkg::*;
#(
  parameter int unsigned TW    = TW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic [TW-1:0] req_timing;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          err_clr;
  logic          out_valid;
  logic [TW-1:0] out_timing;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  modport master (
    output req_valid, req_timing, rsp_valid, rsp_data, err_clr,
    input  out_valid, out_timing, out_data, level, overflow, underflow
  );

  modport slave (
    input  req_valid, req_timing, rsp_valid, rsp_data, err_clr,
    output out_valid, out_timing, out_data, level, overflow, underflow
  );
endinterface

// File: rtl/timing_realign_sync_fifo_ptr.sv
// Pointer, occupancy and full/empty bookkeeping for an in-order FIFO.
module sync_fifo_ptr #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push_c,
  output logic          pop_c,
  output logic          full_c,
  output logic          empty_c,
  output logic [PW-1:0] wp,
  output logic [PW-1:0] rp,
  output logic [CW-1:0] count
);
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  // A pop on empty is refused; a push on full succeeds only alongside a pop
  assign pop_c   = pop_req && !empty_c;
  assign push_c  = push_req && (!full_c || pop_c);

  assign wp    = wp_q;
  assign rp    = rp_q;
  assign count = count_q;

  // Next pointer and count values
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push_c) wp_d = wp_q + PW'(1);
    if (pop_c)  rp_d = rp_q + PW'(1);
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/timing_realign.sv
// Holds timing words of outstanding pixel requests and re-pairs them with returning data.
module timing_realign
  import timing_realign_pkg::*;
#(
  parameter int unsigned TW    = TW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  timing_realign_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic          push_c, pop_c, full_c, empty_c;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_req (bus.req_valid),
    .pop_req  (bus.rsp_valid),
    .push_c   (push_c),
    .pop_c    (pop_c),
    .full_c   (full_c),
    .empty_c  (empty_c),
    .wp       (wp),
    .rp       (rp),
    .count    (count)
  );

  logic [TW-1:0] mem_q [DEPTH];
  logic [TW-1:0] mem_d [DEPTH];
  logic          out_valid_q, out_valid_d;
  logic [TW-1:0] out_timing_q, out_timing_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          ovf_evt_c, unf_evt_c;

  // Dropped request: full, and no pop frees a slot this cycle
  assign ovf_evt_c = bus.req_valid && full_c && !pop_c;
  assign unf_evt_c = bus.rsp_valid && empty_c;

  // Storage write at the write pointer
  always_comb begin
    mem_d = mem_q;
    if (push_c) mem_d[wp] = bus.req_timing;
  end

  // Output pairing and sticky error flags; an error event beats a clear
  always_comb begin
    out_valid_d  = pop_c;
    out_timing_d = out_timing_q;
    out_data_d   = out_data_q;
    if (pop_c) begin
      out_timing_d = mem_q[rp];
      out_data_d   = bus.rsp_data;
    end
    overflow_d  = ovf_evt_c || (overflow_q  && !bus.err_clr);
    underflow_d = unf_evt_c || (underflow_q && !bus.err_clr);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      out_valid_q  <= 1'b0;
      out_timing_q <= '0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      out_valid_q  <= out_valid_d;
      out_timing_q <= out_timing_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_timing = out_timing_q;
  assign bus.out_data   = out_data_q;
  assign bus.level      = count;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_timing_realign.sv
// Directed bench for timing_realign: pairing, ordering, wrap, full/empty corners, async reset.
module tb_timing_realign;
  localparam int unsigned TW    = 38;
  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  timing_realign_if #(.TW(TW), .DW(DW), .DEPTH(DEPTH)) bus ();

  timing_realign #(.TW(TW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, wait past the edge, return inputs to idle
  task automatic step(input logic rv, input logic [37:0] rt,
                      input logic pv, input logic [11:0] pd, input logic ec);
    bus.req_valid  = rv;
    bus.req_timing = rt;
    bus.rsp_valid  = pv;
    bus.rsp_data   = pd;
    bus.err_clr    = ec;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_timing = '0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_data   = '0;
    bus.err_clr    = 1'b0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_timing = '0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_data   = '0;
    bus.err_clr    = 1'b0;

    // Reset state, observed before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid",  64'(bus.out_valid),  64'h0);
    check("rst_out_timing", 64'(bus.out_timing), 64'h0);
    check("rst_out_data",   64'(bus.out_data),   64'h0);
    check("rst_level",      64'(bus.level),      64'h0);
    check("rst_overflow",   64'(bus.overflow),   64'h0);
    check("rst_underflow",  64'(bus.underflow),  64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request/response pair
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 38'h0ABC, 0, 0, 0);
    check("single_level1", 64'(bus.level), 64'd1);
    check("single_noout",  64'(bus.out_valid), 64'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 12'hF00, 0);
    check("single_valid",  64'(bus.out_valid),  64'h1);
    check("single_timing", 64'(bus.out_timing), 64'h0ABC);
    check("single_data",   64'(bus.out_data),   64'hF00);
    check("single_level0", 64'(bus.level),      64'd0);
    step(0, 0, 0, 0, 0);
    check("idle_valid0",   64'(bus.out_valid),  64'h0);
    check("idle_hold_tim", 64'(bus.out_timing), 64'h0ABC);
    check("idle_hold_dat", 64'(bus.out_data),   64'hF00);

    // Order and pointer wrap, three rounds of eight
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step(1, 38'(i + 1), 0, 0, 0);
      check("wrap_full_level", 64'(bus.level), 64'd8);
      check("wrap_no_ovf",     64'(bus.overflow), 64'h0);
      for (int i = 0; i < 8; i++) begin
        step(0, 0, 1, 12'(8'hA0 + i), 0);
        check("wrap_valid",  64'(bus.out_valid),  64'h1);
        check("wrap_timing", 64'(bus.out_timing), 64'(i + 1));
        check("wrap_data",   64'(bus.out_data),   64'(8'hA0 + i));
      end
      check("wrap_empty", 64'(bus.level), 64'd0);
    end

    // Overflow: ninth request dropped
    for (int i = 0; i < 9; i++) step(1, 38'(i + 1), 0, 0, 0);
    check("ovf_level",    64'(bus.level),    64'd8);
    check("ovf_flag",     64'(bus.overflow), 64'h1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 12'h0C0, 0);
      check("ovf_drain_timing", 64'(bus.out_timing), 64'(i + 1));
    end
    step(0, 0, 0, 0, 0);
    check("ovf_no_ninth", 64'(bus.out_valid), 64'h0);
    check("ovf_level0",   64'(bus.level),     64'd0);
    check("ovf_sticky",   64'(bus.overflow),  64'h1);
    check("unf_untouched", 64'(bus.underflow), 64'h0);
    step(0, 0, 0, 0, 1);
    check("ovf_cleared",  64'(bus.overflow),  64'h0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 38'(11 + i), 0, 0, 0);
    check("fullpp_pre_level", 64'(bus.level), 64'd8);
    step(1, 38'd99, 1, 12'h0B1, 0);
    check("fullpp_valid",  64'(bus.out_valid),  64'h1);
    check("fullpp_timing", 64'(bus.out_timing), 64'd11);
    check("fullpp_level",  64'(bus.level),      64'd8);
    check("fullpp_no_ovf", 64'(bus.overflow),   64'h0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 12'h0B2, 0);
      check("fullpp_drain", 64'(bus.out_timing), 64'(12 + i));
    end
    step(0, 0, 1, 12'h0B3, 0);
    check("fullpp_99",     64'(bus.out_timing), 64'd99);
    check("fullpp_level0", 64'(bus.level),      64'd0);

    // Underflow with simultaneous request: no bypass
    step(1, 38'd5, 1, 12'hBAD, 0);
    check("unf_flag",  64'(bus.underflow), 64'h1);
    check("unf_valid", 64'(bus.out_valid), 64'h0);
    check("unf_level", 64'(bus.level),     64'd1);
    step(0, 0, 1, 12'h123, 0);
    check("unf_next_valid",  64'(bus.out_valid),  64'h1);
    check("unf_next_timing", 64'(bus.out_timing), 64'd5);
    check("unf_next_data",   64'(bus.out_data),   64'h123);
    step(0, 0, 1, 12'h456, 1);
    check("unf_set_wins",    64'(bus.underflow), 64'h1);
    check("unf_empty_noout", 64'(bus.out_valid), 64'h0);
    step(0, 0, 0, 0, 1);
    check("unf_cleared",     64'(bus.underflow), 64'h0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1, 38'(21 + i), 0, 0, 0);
    step(0, 0, 1, 12'h777, 0);
    check("mid_pre_timing", 64'(bus.out_timing), 64'd21);
    check("mid_pre_level",  64'(bus.level),      64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  64'(bus.out_valid),  64'h0);
    check("mid_rst_timing", 64'(bus.out_timing), 64'h0);
    check("mid_rst_data",   64'(bus.out_data),   64'h0);
    check("mid_rst_level",  64'(bus.level),      64'h0);
    rst_n = 1'b1;
    step(0, 0, 1, 12'h321, 0);
    check("mid_post_unf",   64'(bus.underflow), 64'h1);
    check("mid_post_valid", 64'(bus.out_valid), 64'h0);
    step(1, 38'd77, 0, 0, 0);
    step(0, 0, 1, 12'h0AA, 0);
    check("mid_fresh_timing", 64'(bus.out_timing), 64'd77);
    check("mid_fresh_level",  64'(bus.level),      64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
